// File: rtl/rr_channel_selecter.sv
// Write-channel selector: fixed-priority / round-robin / forced pick of one requesting port per cycle into a registered valid/ready stage.
// Optional burst lock (define RR_CHSEL_BURST_LOCK_EN) keeps the grant on one port until its last beat; ack is combinational, data is 1 cycle later.
module rr_channel_selecter #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_PORTS  = 16,
    parameter int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_PORTS-1:0]            i_req,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data_in,
    input  logic [NUM_PORTS-1:0]            i_last,
    input  logic                            i_mode,
    input  logic                            i_force_en,
    input  logic [SEL_WIDTH-1:0]            i_force_sel,
    output logic [NUM_PORTS-1:0]            o_ack,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [DATA_WIDTH-1:0]           o_data_out,
    output logic [SEL_WIDTH-1:0]            o_out_idx,
    output logic                            o_locked
);

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [SEL_WIDTH-1:0]  r_out_idx;
    logic [SEL_WIDTH-1:0]  r_ptr;

    logic                  w_load;
    logic                  w_locked;
    logic [NUM_PORTS-1:0]  w_force_mask;
    logic [NUM_PORTS-1:0]  w_elig;
    logic                  w_found;
    logic [SEL_WIDTH-1:0]  w_idx;
    logic                  w_grant;
    logic [NUM_PORTS-1:0]  w_ack;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid || i_out_ready;

`ifdef RR_CHSEL_BURST_LOCK_EN
    logic                 r_lock;
    logic [NUM_PORTS-1:0] r_lock_oh;
    assign w_locked = r_lock;
`else
    logic w_unused_last;
    assign w_locked      = 1'b0;
    assign w_unused_last = ^i_last;
`endif

    // An out-of-range force_sel matches no port and so yields an empty mask.
    always_comb begin
        w_force_mask = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_force_mask[j] = (j == int'(i_force_sel));
        end
        w_elig = i_force_en ? (i_req & w_force_mask) : i_req;
`ifdef RR_CHSEL_BURST_LOCK_EN
        if (r_lock) begin
            w_elig = i_req & r_lock_oh;
        end
`endif
    end

    always_comb begin
        int k;
        w_found = 1'b0;
        w_idx   = '0;
        k       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_mode) begin
                k = int'(r_ptr) + i;
                if (k >= NUM_PORTS) begin
                    k = k - NUM_PORTS;
                end
            end else begin
                k = i;
            end
            if (!w_found && w_elig[SEL_WIDTH'(k)]) begin
                w_found = 1'b1;
                w_idx   = SEL_WIDTH'(k);
            end
        end
    end

    assign w_grant = w_load && w_found && !i_rst;

    always_comb begin
        w_ack      = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (SEL_WIDTH'(j) == w_idx) begin
                w_ack[j]   = w_grant;
                w_sel_data = i_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_idx   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_grant;
                if (w_grant) begin
                    r_data_out <= w_sel_data;
                    r_out_idx  <= w_idx;
                end
            end
            // Pointer is frozen while a burst holds the lock.
            if (w_grant && i_mode && !w_locked) begin
                r_ptr <= (int'(w_idx) == NUM_PORTS - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

`ifdef RR_CHSEL_BURST_LOCK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lock    <= 1'b0;
            r_lock_oh <= '0;
        end else if (w_grant) begin
            r_lock    <= !i_last[w_idx];
            r_lock_oh <= w_ack;
        end
    end
`endif

    assign o_ack       = w_ack;
    assign o_out_valid = r_out_valid;
    assign o_data_out  = r_data_out;
    assign o_out_idx   = r_out_idx;
    assign o_locked    = w_locked;

endmodule

// File: tb/tb_rr_channel_selecter.sv
// Directed bench for rr_channel_selecter: reset, fixed priority, round-robin, backpressure, force and burst lock.
module tb_rr_channel_selecter;

    localparam int DW = 256;
    localparam int NP = 16;
    localparam int SW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req;
    logic [NP*DW-1:0] data_in;
    logic [NP-1:0]    last;
    logic             mode;
    logic             force_en;
    logic [SW-1:0]    force_sel;
    logic [NP-1:0]    ack;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    data_out;
    logic [SW-1:0]    out_idx;
    logic             locked;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_channel_selecter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(SW)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data_in(data_in), .i_last(last),
        .i_mode(mode), .i_force_en(force_en), .i_force_sel(force_sel), .o_ack(ack),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_data_out(data_out),
        .o_out_idx(out_idx), .o_locked(locked)
    );

    function automatic logic [DW-1:0] pdata(input int j);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(j * 7 + 1);
        return {8{w}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx);
        chk({tag, "_valid"}, DW'(out_valid), DW'(1));
        chk({tag, "_idx"}, DW'(out_idx), DW'(idx));
        chk({tag, "_data"}, data_out, pdata(idx));
    endtask

    // Burst table: req/last driven per beat, expected ack and locked after the edge.
    logic [NP-1:0] bt_req  [4] = '{16'h000A, 16'h000A, 16'h000A, 16'h0002};
    logic [NP-1:0] bt_last [4] = '{16'h0002, 16'h0002, 16'h000A, 16'h0002};
`ifdef RR_CHSEL_BURST_LOCK_EN
    int            bt_idx  [4] = '{3, 3, 3, 1};
    logic          bt_lock [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    int            bt_idx  [4] = '{3, 1, 3, 1};
    logic          bt_lock [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        for (int j = 0; j < NP; j++) data_in[j*DW +: DW] = pdata(j);
        rst = 1'b1; req = 16'hFFFF; last = '0; mode = 1'b0;
        force_en = 1'b0; force_sel = '0; out_ready = 1'b1;

        // Reset with everyone requesting
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_ack", DW'(ack), '0);
            @(posedge clk); #1;
            chk("rst_valid", DW'(out_valid), '0);
            chk("rst_data", data_out, '0);
            chk("rst_idx", DW'(out_idx), '0);
            chk("rst_locked", DW'(locked), '0);
        end

        // Fixed priority
        @(negedge clk); rst = 1'b0; mode = 1'b0; req = 16'h0014; #1;
        chk("fp_ack", DW'(ack), DW'(16'h0004));
        @(posedge clk); #1;
        check_beat("fp", 2);

        // Round-robin streaming, one beat per cycle
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); mode = 1'b1; req = 16'hFFFF; #1;
            chk("rr_ack", DW'(ack), DW'(16'(1) << (i % 16)));
            @(posedge clk); #1;
            check_beat("rr", i % 16);
        end

        // Backpressure: ptr is 1, so port 5 wins and is then held
        @(negedge clk); req = 16'h0020; out_ready = 1'b1; #1;
        chk("bp_ack0", DW'(ack), DW'(16'h0020));
        @(posedge clk); #1;
        check_beat("bp_first", 5);
        repeat (3) begin
            @(negedge clk); req = 16'h0001; out_ready = 1'b0; #1;
            chk("bp_stall_ack", DW'(ack), '0);
            @(posedge clk); #1;
            check_beat("bp_hold", 5);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chk("bp_release_ack", DW'(ack), DW'(16'h0001));
        @(posedge clk); #1;
        check_beat("bp_new", 0);

        // Forced select
        @(negedge clk); force_en = 1'b1; force_sel = 4'd9; req = 16'h0201; #1;
        chk("force_ack", DW'(ack), DW'(16'h0200));
        @(posedge clk); #1;
        check_beat("force", 9);
        @(negedge clk); req = 16'h0001; #1;
        chk("force_miss_ack", DW'(ack), '0);
        @(posedge clk); #1;
        chk("force_drop_valid", DW'(out_valid), '0);
        chk("force_hold_idx", DW'(out_idx), DW'(9));

        // Burst: reset, then a port-1 grant leaves ptr at 2 so port 3 wins first
        @(negedge clk); force_en = 1'b0; rst = 1'b1; req = '0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; mode = 1'b1; req = 16'h0002; last = 16'h0002; #1;
        chk("bl_pre_ack", DW'(ack), DW'(16'h0002));
        @(posedge clk); #1;
        check_beat("bl_pre", 1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); req = bt_req[b]; last = bt_last[b]; #1;
            chk("bl_ack", DW'(ack), DW'(16'(1) << bt_idx[b]));
            @(posedge clk); #1;
            check_beat("bl", bt_idx[b]);
            chk("bl_locked", DW'(locked), DW'(bt_lock[b]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_channel_selecter.md
# rr_channel_selecter

Parametrised successor channel selector for the write-arbiter path: picks one of NUM_PORTS requesting write channels per cycle and registers the chosen beat into a valid/ready output stage toward the SRAM write port. Supports fixed-priority and round-robin arbitration, a forced-select override, per-port request/ack handshake and an optional burst-lock mode, with downstream backpressure.

## Interface
- DATA_WIDTH, 256, width of one channel's data beat
- NUM_PORTS, 16, number of input channels (≥2)
- SEL_WIDTH, $clog2(NUM_PORTS), width of index signals
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_PORTS  per-port request; port holds req and data until ack
- data_in  input  NUM_PORTS*DATA_WIDTH  flat bus, port j at [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- last  input  NUM_PORTS  per-port end-of-burst flag (used only with burst lock)
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
- force_en  input  1  override arbitration with force_sel
- force_sel  input  SEL_WIDTH  forced port index
- ack  output  NUM_PORTS  combinational one-hot grant; beat accepted this cycle
- out_valid  output  1  registered beat valid
- out_ready  input  1  downstream accepts beat
- data_out  output  DATA_WIDTH  registered granted data
- out_idx  output  SEL_WIDTH  registered index of granted port
- locked  output  1  burst lock active (0 when feature compiled out)

## Operation
- load = !out_valid || out_ready. No grant when load=0; ack=0.
- Eligible set: req, restricted by force/lock below. Grant only when load=1 and eligible set non-empty.
- mode=0: lowest eligible index wins. mode=1: first eligible index at or after ptr, wrapping NUM_PORTS-1→0.
- ptr updated only on grant in mode=1: ptr ← idx+1, wrapping to 0 at NUM_PORTS. mode=0 leaves ptr untouched; switching modes mid-stream is legal, takes effect same cycle.
- force_en=1: only force_sel eligible; req[force_sel]=0 → no grant. force_sel ≥ NUM_PORTS → no grant.
- On grant: ack[idx]=1, data_out←slice idx, out_idx←idx, out_valid←1.
- load=1, no grant: out_valid←0; data_out/out_idx hold.
- load=0: all output registers hold.
- Reset: out_valid=0, data_out=0, out_idx=0, ptr=0, lock cleared, locked=0; ack forced 0 while rst=1.

## Timing
- req → ack: 0 cycles (combinational). ack → out_valid/data_out: 1 cycle.
- Throughput one beat/cycle with out_ready=1 held.
- Beat presented with out_valid=1, out_ready=0 stays stable until accepted.
- rst mid-burst: beat in output stage discarded, lock and ptr cleared next edge.
- Simultaneous grant and consume: old beat leaves, new beat loads same edge, out_valid stays 1.

## Configuration
- RR_CHSEL_BURST_LOCK_EN defined: grant to port p with last[p]=0 sets lock on p; while locked only p eligible (force_en and mode ignored, ptr frozen); req[p]=0 → bubble; grant with last[p]=1 clears lock; locked mirrors lock register.
- Not defined: last ignored, each beat arbitrated independently, locked tied 0.

## Test plan
- Reset: rst=1 two cycles with req=0xFFFF → ack=0, out_valid=0, data_out=0, out_idx=0.
- Fixed priority: mode=0, req=0x0014, out_ready=1 → ack=0x0004; next cycle out_valid=1, out_idx=2, data_out=port 2 data.
- Round-robin: mode=1, req=0xFFFF, out_ready=1 for 17 cycles → out_idx sequence 0,1,…,15,0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req=0x0001 → ack=0, data_out/out_idx stable; out_ready=1 → ack=0x0001 same cycle, new beat next cycle.
- Force: force_en=1, force_sel=9, req=0x0201 → ack=0x0200, out_idx=9; req=0x0001 → ack=0, out_valid drops after consumption.
- Burst lock (macro on): mode=1, port 3 beats with last=0,0,1 while req[1]=1 → out_idx 3,3,3 then 1, locked=1 during first two; macro off → out_idx alternates 1/3 per round-robin.
